// File: rtl/hex_display_mux.sv
// Time-multiplexed hex driver for common-anode 7-segment banks, with frame-synchronous value staging.
// Define HEX_BLINK_EN to add the BLINK_MASK input and per-digit blink.
module hex_display_mux #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_DIV  = 16,
    parameter int unsigned BLINK_DIV = 32
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] VALUE,
    input  logic                BLANK_LZ,
`ifdef HEX_BLINK_EN
    input  logic [DIGITS-1:0]   BLINK_MASK,
`endif
    output logic                READY,
    output logic [6:0]          SEG,
    output logic [DIGITS-1:0]   DIG,
    output logic                FRAME
);

    localparam int unsigned   CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned   IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    if (DIGITS < 1 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_params
        $error("hex_display_mux: invalid parameter values");
    end

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                pending_q, pending_d;
    logic                frame_q, frame_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;

    logic                dwell_end;
    logic                wrap;
    logic                accept;
    logic [3:0]          cur_nib;
    logic                lz_blank;
    logic                blink_blank;
    logic [DIGITS-1:0]   lz_vec;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h18;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign dwell_end = (cnt_q == CNT_LAST);
    assign wrap      = dwell_end && (idx_q == IDX_LAST);
    assign accept    = LOAD && !pending_q;

    // Digit k is a leading zero when it and every more significant digit are zero; digit 0 never is.
    always_comb begin
        logic run_zero;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        lz_vec   = '0;
        run_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run_zero  = run_zero && (disp_q[4*k +: 4] == 4'h0);
            lz_vec[k] = run_zero;
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        lz_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib  = disp_q[4*k +: 4];
                lz_blank = lz_vec[k];
            end
        end
    end

`ifdef HEX_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_d  = '0;
                phase_d = !phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        blink_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                blink_blank = phase_q && BLINK_MASK[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    assign blink_blank = 1'b0;
`endif

    always_comb begin
        cnt_d = dwell_end ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (dwell_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        frame_d = wrap;

        // A capture in the wrap cycle only sets pending; it is applied at the following wrap.
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            shadow_d  = VALUE;
            pending_d = 1'b1;
        end

        seg_d = ((BLANK_LZ && lz_blank) || blink_blank) ? 7'h7F : hex_to_seg(cur_nib);

        // Dark during dwell count 0 so the previous digit's segments never ghost onto the next anode.
        dig_d = '1;
        if (cnt_q != '0) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx_q == IW'(k)) begin
                    dig_d[k] = 1'b0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            seg_q     <= 7'h7F;
            dig_q     <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
        end
    end

    assign READY = !pending_q;
    assign SEG   = seg_q;
    assign DIG   = dig_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
// Blink checks are compiled in only when HEX_BLINK_EN is defined.
`timescale 1ns/1ps
module tb_hex_display_mux;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic        CLK      = 1'b0;
    logic        RESETN   = 1'b0;
    logic        LOAD     = 1'b0;
    logic [15:0] VALUE    = 16'h0000;
    logic        BLANK_LZ = 1'b0;
`ifdef HEX_BLINK_EN
    logic [3:0]  BLINK_MASK = 4'b0001;
`endif
    logic        READY;
    logic [6:0]  SEG;
    logic [3:0]  DIG;
    logic        FRAME;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    hex_display_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .LOAD      (LOAD),
        .VALUE     (VALUE),
        .BLANK_LZ  (BLANK_LZ),
`ifdef HEX_BLINK_EN
        .BLINK_MASK(BLINK_MASK),
`endif
        .READY     (READY),
        .SEG       (SEG),
        .DIG       (DIG),
        .FRAME     (FRAME)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (FRAME !== 1'b1 && n < 200);
        check({tag, "_frame_seen"}, 32'(FRAME), 32'd1);
    endtask

    // Starts at a frame boundary; exp packs expected SEG as {d3,d2,d1,d0}; ends at the next boundary.
    task automatic check_frame(input string tag, input logic [27:0] exp);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                logic [3:0] dig_exp;
                tick();
                if (c == 0) begin
                    check($sformatf("%s_d%0d_dark", tag, d), 32'(DIG), 32'hF);
                end else begin
                    dig_exp    = 4'hF;
                    dig_exp[d] = 1'b0;
                    check($sformatf("%s_d%0d_c%0d_dig", tag, d, c), 32'(DIG), 32'(dig_exp));
                    check($sformatf("%s_d%0d_c%0d_seg", tag, d, c), 32'(SEG), 32'(exp[7*d +: 7]));
                end
            end
        end
        check({tag, "_frame"}, 32'(FRAME), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},   32'(SEG),   32'h7F);
        check({tag, "_dig"},   32'(DIG),   32'hF);
        check({tag, "_ready"}, 32'(READY), 32'd1);
        check({tag, "_frame"}, 32'(FRAME), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state and first-frame latency.
        RESETN = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        RESETN = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (FRAME !== 1'b1 && n < 100);
        check("first_frame_latency", n, 32'd16);

        // Staged load applied at the next frame boundary.
        LOAD  = 1'b1;
        VALUE = 16'h1A3F;
        tick();
        LOAD = 1'b0;
        check("t2_ready_low", 32'(READY), 32'd0);
        wait_frame("t2");
        check("t2_ready_high", 32'(READY), 32'd1);
        check_frame("t2", {7'h79, 7'h08, 7'h30, 7'h0E});

        // Second load while not ready is ignored; leading zeros blanked.
        LOAD  = 1'b1;
        VALUE = 16'h0042;
        tick();
        VALUE = 16'h00FF;
        tick();
        LOAD = 1'b0;
        check("t3_ready_low", 32'(READY), 32'd0);
        BLANK_LZ = 1'b1;
        wait_frame("t3");
        check("t3_ready_high", 32'(READY), 32'd1);
        check_frame("t3", {7'h7F, 7'h7F, 7'h19, 7'h24});

        // An embedded zero below a nonzero digit is not blanked.
        LOAD  = 1'b1;
        VALUE = 16'h0100;
        tick();
        LOAD = 1'b0;
        wait_frame("t3b");
        check_frame("t3b", {7'h7F, 7'h79, 7'h40, 7'h40});

        // All-zero value shows a single 0.
        LOAD  = 1'b1;
        VALUE = 16'h0000;
        tick();
        LOAD = 1'b0;
        wait_frame("t4");
        check_frame("t4", {7'h7F, 7'h7F, 7'h7F, 7'h40});

        // Load accepted on the wrap cycle itself takes effect one frame later.
        BLANK_LZ = 1'b0;
        repeat (15) tick();
        LOAD  = 1'b1;
        VALUE = 16'hBEC7;
        tick();
        LOAD = 1'b0;
        check("t5_wrap_align", 32'(FRAME), 32'd1);
        check("t5_ready_low", 32'(READY), 32'd0);
        check_frame("t5_old", {7'h40, 7'h40, 7'h40, 7'h40});
        check("t5_ready_high", 32'(READY), 32'd1);
        check_frame("t5_new", {7'h03, 7'h06, 7'h46, 7'h78});

        // Reset mid-frame with a pending load discards it and clears the display.
        LOAD  = 1'b1;
        VALUE = 16'h5555;
        tick();
        LOAD = 1'b0;
        repeat (5) tick();
        check("t7_pending", 32'(READY), 32'd0);
        RESETN = 1'b0;
        tick();
        check_reset_outputs("t7_rst");
        RESETN = 1'b1;
        check_frame("t7_f0", {7'h40, 7'h40, 7'h40, 7'h40});
        check("t7_ready", 32'(READY), 32'd1);
        check_frame("t7_f1", {7'h40, 7'h40, 7'h40, 7'h40});

`ifdef HEX_BLINK_EN
        // Blink phase toggles every BLINK_DIV frames; only digit 0 is masked.
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        for (int f = 0; f < 10; f++) begin
            check_frame($sformatf("t6_f%0d", f),
                        {7'h40, 7'h40, 7'h40, ((f % 4) >= 2) ? 7'h7F : 7'h40});
        end
        repeat (3) tick();
        check("t6_mid_dig", 32'(DIG), 32'hE);
        check("t6_mid_seg", 32'(SEG), 32'h7F);
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        check_frame("t6_rst_f0", {7'h40, 7'h40, 7'h40, 7'h40});
        check_frame("t6_rst_f1", {7'h40, 7'h40, 7'h40, 7'h40});
        check_frame("t6_rst_f2", {7'h40, 7'h40, 7'h40, 7'h7F});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
